// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted-write FIFO between the cache memory port and main memory.
// Writes are acked in one cycle and drained in the background; reads wait for
// the buffer to empty, then pass through, so memory sees requests in order.
// Optional macro: WB_FORWARD_EN -- a read hitting the youngest full-word
// buffered write is answered from the buffer without a memory access.
// Ports:
//   clk, resetn                        clock, async active-low reset
//   up_valid/addr/wdata/wstrb (in)     cache request (wstrb==0 is a read)
//   up_ready/up_rdata (out)            1-cycle completion pulse and read data
//   dn_valid/addr/wdata/wstrb (out)    memory request, held until dn_ready
//   dn_ready/dn_rdata (in)             memory completion pulse and read data
//   wb_count/wb_full (out)             occupancy and full flag
module mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           up_valid,
  input  logic [31:0]    up_addr,
  input  logic [31:0]    up_wdata,
  input  logic [3:0]     up_wstrb,
  output logic           up_ready,
  output logic [31:0]    up_rdata,
  output logic           dn_valid,
  output logic [31:0]    dn_addr,
  output logic [31:0]    dn_wdata,
  output logic [3:0]     dn_wstrb,
  input  logic           dn_ready,
  input  logic [31:0]    dn_rdata,
  output logic [PTR_W:0] wb_count,
  output logic           wb_full
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_RD_DRAIN,
    S_RD_ISSUE,
    S_RD_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  strb_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d;

  logic        up_ready_q, up_ready_d;
  logic [31:0] up_rdata_q, up_rdata_d;
  logic        dn_valid_q, dn_valid_d;
  logic [31:0] dn_addr_q, dn_addr_d;
  logic [31:0] dn_wdata_q, dn_wdata_d;
  logic [3:0]  dn_wstrb_q, dn_wstrb_d;

  logic        req_new;
  logic        is_wr;
  logic        push;
  logic        pop;
  logic        drain_go;
  logic        fwd_ok;
  logic [31:0] fwd_data;

  // While up_ready is high the cache still holds the finished request;
  // it must not be taken as a new one.
  assign req_new  = up_valid & ~up_ready_q;
  assign is_wr    = |up_wstrb;
  assign push     = (state_q == S_IDLE) & req_new & is_wr
                  & (count_q != FULL_CNT);
  // A dn_ready outside RD_WAIT can only complete a drain.
  assign pop      = dn_valid_q & dn_ready & (state_q != S_RD_WAIT);
  assign drain_go = (count_q != '0) & ~dn_valid_q
                  & (state_q != S_RD_ISSUE)
                  & (state_q != S_RD_WAIT);

  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  assign count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign full_d   = (count_d == FULL_CNT);

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest; the last match is the youngest write.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_ok   = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) &&
          (addr_q[idx][31:2] == up_addr[31:2])) begin
        fwd_ok   = (strb_q[idx] == 4'hF);
        fwd_data = data_q[idx];
      end
    end
  end
`else
  assign fwd_ok   = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= up_addr;
      data_q[wr_ptr_q] <= up_wdata;
      strb_q[wr_ptr_q] <= up_wstrb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_new) begin
          if (!is_wr)    state_d = S_RD_DRAIN;
          else if (push) state_d = S_ACK;
        end
      end
      S_ACK: state_d = S_IDLE;
      S_RD_DRAIN: begin
        if (fwd_ok)
          state_d = S_IDLE;
        else if (count_q == '0 && !dn_valid_q)
          state_d = S_RD_ISSUE;
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (dn_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    up_ready_d = 1'b0;
    up_rdata_d = up_rdata_q;
    dn_valid_d = dn_valid_q;
    dn_addr_d  = dn_addr_q;
    dn_wdata_d = dn_wdata_q;
    dn_wstrb_d = dn_wstrb_q;
    if (pop) dn_valid_d = 1'b0;
    if (drain_go) begin
      dn_valid_d = 1'b1;
      dn_addr_d  = addr_q[rd_ptr_q];
      dn_wdata_d = data_q[rd_ptr_q];
      dn_wstrb_d = strb_q[rd_ptr_q];
    end
    unique case (state_q)
      S_IDLE: begin
        if (push) up_ready_d = 1'b1;
      end
      S_RD_DRAIN: begin
        if (fwd_ok) begin
          up_ready_d = 1'b1;
          up_rdata_d = fwd_data;
        end
      end
      S_RD_ISSUE: begin
        dn_valid_d = 1'b1;
        dn_addr_d  = up_addr;
        dn_wdata_d = '0;
        dn_wstrb_d = 4'h0;
      end
      S_RD_WAIT: begin
        if (dn_ready) begin
          up_ready_d = 1'b1;
          up_rdata_d = dn_rdata;
          dn_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      up_ready_q <= 1'b0;
      up_rdata_q <= '0;
      dn_valid_q <= 1'b0;
      dn_addr_q  <= '0;
      dn_wdata_q <= '0;
      dn_wstrb_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      up_ready_q <= up_ready_d;
      up_rdata_q <= up_rdata_d;
      dn_valid_q <= dn_valid_d;
      dn_addr_q  <= dn_addr_d;
      dn_wdata_q <= dn_wdata_d;
      dn_wstrb_q <= dn_wstrb_d;
    end
  end

  assign up_ready = up_ready_q;
  assign up_rdata = up_rdata_q;
  assign dn_valid = dn_valid_q;
  assign dn_addr  = dn_addr_q;
  assign dn_wdata = dn_wdata_q;
  assign dn_wstrb = dn_wstrb_q;
  assign wb_count = count_q;
  assign wb_full  = full_q;

endmodule
